// File: rtl/zeroheti_obi_arb.sv
// N-to-1 round-robin OBI arbiter with an in-order ID FIFO for response routing.
// The request and response paths are combinational, so neither adds latency.
module zeroheti_obi_arb #(
  parameter int unsigned NumMgr    = 2,
  parameter int unsigned MaxTrans  = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumMgr-1:0]               mgr_req_i,
  output logic [NumMgr-1:0]               mgr_gnt_o,
  input  logic [NumMgr*AddrWidth-1:0]     mgr_addr_i,
  input  logic [NumMgr-1:0]               mgr_we_i,
  input  logic [NumMgr*DataWidth/8-1:0]   mgr_be_i,
  input  logic [NumMgr*DataWidth-1:0]     mgr_wdata_i,
  output logic [NumMgr-1:0]               mgr_rvalid_o,
  output logic [DataWidth-1:0]            mgr_rdata_o,
  output logic                            mgr_err_o,
  output logic                            sbr_req_o,
  input  logic                            sbr_gnt_i,
  output logic [AddrWidth-1:0]            sbr_addr_o,
  output logic                            sbr_we_o,
  output logic [DataWidth/8-1:0]          sbr_be_o,
  output logic [DataWidth-1:0]            sbr_wdata_o,
  input  logic                            sbr_rvalid_i,
  input  logic [DataWidth-1:0]            sbr_rdata_i,
  input  logic                            sbr_err_i,
  output logic                            unexp_rsp_o
);

  localparam int unsigned IdxW = (NumMgr > 1) ? $clog2(NumMgr) : 1;
  localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int unsigned CntW = $clog2(MaxTrans + 1);
  localparam int unsigned BeW  = DataWidth / 8;

  typedef enum logic {ARB, HOLD} state_e;

  state_e          state_q;
  logic [IdxW-1:0] rr_q, lock_q, winner, sel, cand;
  logic            found, not_full, push, pop;
  logic [CntW-1:0] count_q;
  logic [PtrW-1:0] wr_q, rd_q;
  logic [IdxW-1:0] fifo_q [MaxTrans];
  logic            unexp_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxTrans - 1)) ? '0 : p + 1'b1;
  endfunction

  assign not_full = (count_q < CntW'(MaxTrans));

  // Round-robin search: first requester at or after the pointer, wrapping upward.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 0; i < NumMgr; i++) begin
      cand = IdxW'((32'(rr_q) + i) % NumMgr);
      if (!found && mgr_req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Selection, grant fan-out and response routing; HOLD pins the locked manager.
  always_comb begin
    sel          = (state_q == HOLD) ? lock_q : winner;
    sbr_req_o    = 1'b0;
    mgr_gnt_o    = '0;
    mgr_rvalid_o = '0;
    if (!rst_i) sbr_req_o = (state_q == HOLD) || (found && not_full);
    if (sbr_req_o) mgr_gnt_o[sel] = sbr_gnt_i;
    push = sbr_req_o & sbr_gnt_i;
    pop  = !rst_i && sbr_rvalid_i && (count_q != '0);
    if (pop) mgr_rvalid_o[fifo_q[rd_q]] = 1'b1;
  end

  assign sbr_addr_o  = mgr_addr_i[sel*AddrWidth +: AddrWidth];
  assign sbr_we_o    = mgr_we_i[sel];
  assign sbr_be_o    = mgr_be_i[sel*BeW +: BeW];
  assign sbr_wdata_o = mgr_wdata_i[sel*DataWidth +: DataWidth];
  assign mgr_rdata_o = sbr_rdata_i;
  assign mgr_err_o   = sbr_err_i;
  assign unexp_rsp_o = unexp_q;

  // Arbitration FSM: lock selection while the subordinate withholds grant, advance RR on grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB;
      rr_q    <= '0;
      lock_q  <= '0;
    end else begin
      case (state_q)
        ARB: if (sbr_req_o && !sbr_gnt_i) begin
          state_q <= HOLD;
          lock_q  <= winner;
        end
        HOLD: if (sbr_gnt_i) state_q <= ARB;
        default: state_q <= ARB;
      endcase
      if (push) rr_q <= (sel == IdxW'(NumMgr - 1)) ? '0 : sel + 1'b1;
    end
  end

  // Outstanding-transaction bookkeeping and sticky unexpected-response flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      unexp_q <= 1'b0;
    end else begin
      if (push) wr_q <= ptr_inc(wr_q);
      if (pop)  rd_q <= ptr_inc(rd_q);
      count_q <= count_q + CntW'(push) - CntW'(pop);
      if (sbr_rvalid_i && (count_q == '0)) unexp_q <= 1'b1;
    end
  end

  // ID storage: records which manager owns each granted transaction.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_q] <= sel;
  end

`ifndef SYNTHESIS
  hold_stable_a: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == HOLD) |-> $stable({sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o}));
  no_push_full_a: assert property (@(posedge clk_i) disable iff (rst_i)
    push |-> not_full);
`endif

endmodule

// File: tb/tb_zeroheti_obi_arb.sv
// Testbench for zeroheti_obi_arb: directed cycle table plus randomized traffic
// checked against a queue-based reference model.
module tb_zeroheti_obi_arb;
  localparam int N  = 2;
  localparam int MT = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [N-1:0]      mgr_req_i, mgr_gnt_o, mgr_we_i, mgr_rvalid_o;
  logic [N*AW-1:0]   mgr_addr_i;
  logic [N*DW/8-1:0] mgr_be_i;
  logic [N*DW-1:0]   mgr_wdata_i;
  logic [DW-1:0]     mgr_rdata_o, sbr_wdata_o, sbr_rdata_i;
  logic              mgr_err_o, sbr_req_o, sbr_gnt_i, sbr_we_o;
  logic              sbr_rvalid_i, sbr_err_i, unexp_rsp_o;
  logic [AW-1:0]     sbr_addr_o;
  logic [DW/8-1:0]   sbr_be_o;

  zeroheti_obi_arb #(.NumMgr(N), .MaxTrans(MT), .AddrWidth(AW), .DataWidth(DW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .mgr_req_i(mgr_req_i), .mgr_gnt_o(mgr_gnt_o), .mgr_addr_i(mgr_addr_i),
    .mgr_we_i(mgr_we_i), .mgr_be_i(mgr_be_i), .mgr_wdata_i(mgr_wdata_i),
    .mgr_rvalid_o(mgr_rvalid_o), .mgr_rdata_o(mgr_rdata_o), .mgr_err_o(mgr_err_o),
    .sbr_req_o(sbr_req_o), .sbr_gnt_i(sbr_gnt_i), .sbr_addr_o(sbr_addr_o),
    .sbr_we_o(sbr_we_o), .sbr_be_o(sbr_be_o), .sbr_wdata_o(sbr_wdata_o),
    .sbr_rvalid_i(sbr_rvalid_i), .sbr_rdata_i(sbr_rdata_i), .sbr_err_i(sbr_err_i),
    .unexp_rsp_o(unexp_rsp_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic        sgnt;
    logic        rv;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  e_gnt;
    logic        e_sreq;
    logic [31:0] e_addr;
    logic [1:0]  e_rvld;
    logic        e_err;
    logic        e_unexp;
  } vec_t;

  vec_t tbl[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Per-manager payload currently presented on the manager buses.
  logic [31:0] pa[N];
  logic [31:0] pw[N];
  logic [3:0]  pb[N];
  logic        pwe[N];
  bit          pend[N];

  // Reference model state.
  int rr_m, lock_m;
  int q[$];

  function automatic vec_t v(logic rst, logic [1:0] req, logic g, logic rv, logic [31:0] rd,
                             logic er, logic [1:0] eg, logic es, logic [31:0] ea,
                             logic [1:0] erv, logic ee, logic eu);
    vec_t t;
    t.rst = rst; t.req = req; t.sgnt = g; t.rv = rv; t.rdata = rd; t.err = er;
    t.e_gnt = eg; t.e_sreq = es; t.e_addr = ea; t.e_rvld = erv; t.e_err = ee; t.e_unexp = eu;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_payload();
    for (int m = 0; m < N; m++) begin
      mgr_addr_i[m*AW +: AW]       = pa[m];
      mgr_wdata_i[m*DW +: DW]      = pw[m];
      mgr_be_i[m*(DW/8) +: (DW/8)] = pb[m];
      mgr_we_i[m]                  = pwe[m];
    end
  endtask

  initial begin
    rst_i = 1'b1; mgr_req_i = '0; sbr_gnt_i = 1'b0; sbr_rvalid_i = 1'b0;
    sbr_rdata_i = '0; sbr_err_i = 1'b0;
    pa[0] = 32'h100; pa[1] = 32'h200;
    for (int m = 0; m < N; m++) begin pw[m] = '0; pb[m] = 4'hF; pwe[m] = 1'b0; pend[m] = 1'b0; end
    drive_payload();

    //       rst req  g  rv rdata         er | gnt sreq addr      rvld err unexp
    tbl.push_back(v(1, 2'b00, 0, 0, 32'h0,        0, 2'b00, 0, 32'h0,   2'b00, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 0, 32'h0,        0, 2'b00, 0, 32'h0,   2'b00, 0, 0));
    tbl.push_back(v(0, 2'b01, 1, 0, 32'h0,        0, 2'b01, 1, 32'h100, 2'b00, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 1, 32'hDEADBEEF, 0, 2'b00, 0, 32'h0,   2'b01, 0, 0));
    tbl.push_back(v(1, 2'b00, 0, 0, 32'h0,        0, 2'b00, 0, 32'h0,   2'b00, 0, 0));
    tbl.push_back(v(0, 2'b11, 1, 0, 32'h0,        0, 2'b01, 1, 32'h100, 2'b00, 0, 0));
    tbl.push_back(v(0, 2'b11, 1, 1, 32'hA0,       0, 2'b10, 1, 32'h200, 2'b01, 0, 0));
    tbl.push_back(v(0, 2'b11, 1, 1, 32'hA1,       0, 2'b01, 1, 32'h100, 2'b10, 0, 0));
    tbl.push_back(v(0, 2'b11, 1, 1, 32'hA2,       0, 2'b10, 1, 32'h200, 2'b01, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 1, 32'hA3,       0, 2'b00, 0, 32'h0,   2'b10, 0, 0));
    tbl.push_back(v(0, 2'b01, 1, 0, 32'h0,        0, 2'b01, 1, 32'h100, 2'b00, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 1, 32'hB0,       0, 2'b00, 0, 32'h0,   2'b01, 0, 0));
    tbl.push_back(v(0, 2'b11, 0, 0, 32'h0,        0, 2'b00, 1, 32'h200, 2'b00, 0, 0));
    tbl.push_back(v(0, 2'b11, 0, 0, 32'h0,        0, 2'b00, 1, 32'h200, 2'b00, 0, 0));
    tbl.push_back(v(0, 2'b11, 0, 0, 32'h0,        0, 2'b00, 1, 32'h200, 2'b00, 0, 0));
    tbl.push_back(v(0, 2'b11, 1, 0, 32'h0,        0, 2'b10, 1, 32'h200, 2'b00, 0, 0));
    tbl.push_back(v(0, 2'b01, 1, 1, 32'hB1,       1, 2'b01, 1, 32'h100, 2'b10, 1, 0));
    tbl.push_back(v(0, 2'b00, 0, 1, 32'hB2,       0, 2'b00, 0, 32'h0,   2'b01, 0, 0));
    tbl.push_back(v(0, 2'b01, 1, 0, 32'h0,        0, 2'b01, 1, 32'h100, 2'b00, 0, 0));
    tbl.push_back(v(0, 2'b10, 1, 0, 32'h0,        0, 2'b10, 1, 32'h200, 2'b00, 0, 0));
    tbl.push_back(v(0, 2'b01, 1, 0, 32'h0,        0, 2'b00, 0, 32'h0,   2'b00, 0, 0));
    tbl.push_back(v(0, 2'b01, 1, 1, 32'hC0,       0, 2'b00, 0, 32'h0,   2'b01, 0, 0));
    tbl.push_back(v(0, 2'b01, 1, 0, 32'h0,        0, 2'b01, 1, 32'h100, 2'b00, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 1, 32'hC1,       0, 2'b00, 0, 32'h0,   2'b10, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 1, 32'hC2,       0, 2'b00, 0, 32'h0,   2'b01, 0, 0));
    tbl.push_back(v(0, 2'b11, 1, 0, 32'h0,        0, 2'b10, 1, 32'h200, 2'b00, 0, 0));
    tbl.push_back(v(0, 2'b01, 1, 0, 32'h0,        0, 2'b01, 1, 32'h100, 2'b00, 0, 0));
    tbl.push_back(v(1, 2'b11, 1, 1, 32'hD,        0, 2'b00, 0, 32'h0,   2'b00, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 1, 32'hD0,       0, 2'b00, 0, 32'h0,   2'b00, 0, 0));
    tbl.push_back(v(0, 2'b00, 0, 0, 32'h0,        0, 2'b00, 0, 32'h0,   2'b00, 0, 1));
    tbl.push_back(v(0, 2'b01, 1, 0, 32'h0,        0, 2'b01, 1, 32'h100, 2'b00, 0, 1));
    tbl.push_back(v(0, 2'b00, 0, 1, 32'hD1,       0, 2'b00, 0, 32'h0,   2'b01, 0, 1));
    tbl.push_back(v(1, 2'b00, 0, 0, 32'h0,        0, 2'b00, 0, 32'h0,   2'b00, 0, 1));
    tbl.push_back(v(0, 2'b00, 0, 0, 32'h0,        0, 2'b00, 0, 32'h0,   2'b00, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_i = tbl[i].rst; mgr_req_i = tbl[i].req; sbr_gnt_i = tbl[i].sgnt;
      sbr_rvalid_i = tbl[i].rv; sbr_rdata_i = tbl[i].rdata; sbr_err_i = tbl[i].err;
      #1;
      chk($sformatf("tbl%0d gnt", i), 64'(mgr_gnt_o), 64'(tbl[i].e_gnt));
      chk($sformatf("tbl%0d sreq", i), 64'(sbr_req_o), 64'(tbl[i].e_sreq));
      if (tbl[i].e_sreq) chk($sformatf("tbl%0d addr", i), 64'(sbr_addr_o), 64'(tbl[i].e_addr));
      chk($sformatf("tbl%0d rvalid", i), 64'(mgr_rvalid_o), 64'(tbl[i].e_rvld));
      if (tbl[i].e_rvld != 2'b00) begin
        chk($sformatf("tbl%0d rdata", i), 64'(mgr_rdata_o), 64'(tbl[i].rdata));
        chk($sformatf("tbl%0d err", i), 64'(mgr_err_o), 64'(tbl[i].e_err));
      end
      chk($sformatf("tbl%0d unexp", i), 64'(unexp_rsp_o), 64'(tbl[i].e_unexp));
    end

    // Randomized traffic: managers hold request and payload until granted.
    @(negedge clk);
    rst_i = 1'b1; mgr_req_i = '0; sbr_gnt_i = 1'b0; sbr_rvalid_i = 1'b0;
    rr_m = 0; lock_m = -1; q.delete();
    @(negedge clk);
    rst_i = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      int          sel;
      logic        es;
      logic [1:0]  eg, erv;
      if (cyc != 0) @(negedge clk);
      for (int m = 0; m < N; m++) begin
        if (!pend[m] && ($urandom_range(2) != 0)) begin
          pend[m] = 1'b1;
          pa[m] = $urandom; pw[m] = $urandom; pb[m] = 4'($urandom); pwe[m] = 1'($urandom);
        end
        mgr_req_i[m] = pend[m];
      end
      drive_payload();
      sbr_gnt_i    = ($urandom_range(3) != 0);
      sbr_rvalid_i = (q.size() > 0) && ($urandom_range(1) == 1);
      sbr_rdata_i  = $urandom;
      sbr_err_i    = 1'($urandom);
      #1;
      sel = -1; es = 1'b0;
      if (lock_m >= 0) begin
        sel = lock_m; es = 1'b1;
      end else if (q.size() < MT) begin
        for (int k = 0; k < N; k++)
          if (sel < 0 && pend[(rr_m + k) % N]) sel = (rr_m + k) % N;
        es = (sel >= 0);
      end
      eg = '0;
      if (es && sbr_gnt_i) eg[sel] = 1'b1;
      erv = '0;
      if (sbr_rvalid_i && q.size() > 0) erv[q[0]] = 1'b1;
      chk("rnd gnt", 64'(mgr_gnt_o), 64'(eg));
      chk("rnd sreq", 64'(sbr_req_o), 64'(es));
      if (es) begin
        chk("rnd addr", 64'(sbr_addr_o), 64'(pa[sel]));
        chk("rnd wdata", 64'(sbr_wdata_o), 64'(pw[sel]));
        chk("rnd be", 64'(sbr_be_o), 64'(pb[sel]));
        chk("rnd we", 64'(sbr_we_o), 64'(pwe[sel]));
      end
      chk("rnd rvalid", 64'(mgr_rvalid_o), 64'(erv));
      if (erv != '0) begin
        chk("rnd rdata", 64'(mgr_rdata_o), 64'(sbr_rdata_i));
        chk("rnd err", 64'(mgr_err_o), 64'(sbr_err_i));
      end
      chk("rnd unexp", 64'(unexp_rsp_o), 64'(0));
      if (erv != '0) void'(q.pop_front());
      if (es && sbr_gnt_i) begin
        q.push_back(sel);
        rr_m = (sel + 1) % N;
        lock_m = -1;
        pend[sel] = 1'b0;
      end else if (es) begin
        lock_m = sel;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
